// File: rtl/nios2_sopc_pi_knn_resultado_classe.sv
// ---------------------------------------------------------------------------
// nios2_sopc_pi_knn_resultado_classe
//
// Avalon-MM parallel-input port that receives the class result of the KNN
// classifier. It synchronizes the external bus, captures rising edges per
// bit, and raises a maskable level interrupt.
//
// Register map (word address):
//   0  data         synchronized in_port value (read only)
//   1  reserved     reads 0, writes ignored
//   2  irqmask      per-bit interrupt enable (read/write)
//   3  edgecapture  sticky rising-edge flags, write 1 to clear
//
// Ports:
//   clk         system clock, rising edge active
//   reset_n     asynchronous active-low reset
//   address     word address of the access
//   chipselect  slave select, qualifies writes
//   write_n     active-low write strobe
//   writedata   write data, bits [WIDTH-1:0] used
//   in_port     asynchronous class-result input
//   readdata    registered read data (1-cycle latency), zero-extended
//   irq         level interrupt, high when any enabled flag is set
// ---------------------------------------------------------------------------
module nios2_sopc_pi_knn_resultado_classe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGE  = 2'd3;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] edge_clear;
    logic [WIDTH-1:0] read_mux;
    logic             wr_strobe;

    // Only the low WIDTH bits of writedata are meaningful.
    logic unused_writedata;
    assign unused_writedata = ^writedata;

    assign wr_strobe = chipselect & ~write_n;
    assign rise      = sync2 & ~prev;

    always_comb begin
        edge_clear = '0;
        if (wr_strobe && address == ADDR_EDGE) begin
            edge_clear = writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        read_mux = '0;
        case (address)
            ADDR_DATA: read_mux = sync2;
            ADDR_MASK: read_mux = irq_mask;
            ADDR_EDGE: read_mux = edge_capture;
            default:   read_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1        <= '0;
            sync2        <= '0;
            prev         <= '0;
            edge_capture <= '0;
            irq_mask     <= '0;
            readdata     <= '0;
        end else begin
            // Two-flop synchronizer followed by the edge-history register.
            sync1 <= in_port;
            sync2 <= sync1;
            prev  <= sync2;

            // A new rising edge overrides a simultaneous software clear.
            edge_capture <= (edge_capture & ~edge_clear) | rise;

            if (wr_strobe && address == ADDR_MASK) begin
                irq_mask <= writedata[WIDTH-1:0];
            end

            // Read data is refreshed every cycle regardless of chipselect.
            readdata <= 32'(read_mux);
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_nios2_sopc_pi_knn_resultado_classe.sv
module tb_nios2_sopc_pi_knn_resultado_classe;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   readdata;
    logic          irq;

    int n_cmp = 0;
    int n_err = 0;

    nios2_sopc_pi_knn_resultado_classe #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Reference model: the block "sees" in_port as it was two clock edges
    // ago; an edge is a bit that is 1 in that view and 0 one edge earlier.
    logic [W-1:0]  seen [3];   // seen[k] = in_port sampled k+1 edges back
    logic [W-1:0]  m_ec;
    logic [W-1:0]  m_mask;
    logic [31:0]   m_rd;

    always @(posedge clk or negedge reset_n) begin
        logic [W-1:0] visible, visible_before, clr;
        bit wr;
        if (!reset_n) begin
            m_ec   = '0;
            m_mask = '0;
            m_rd   = '0;
            for (int k = 0; k < 3; k++) seen[k] = '0;
        end else begin
            visible        = seen[1];
            visible_before = seen[2];
            wr = chipselect && !write_n;
            case (address)
                2'd0:    m_rd = 32'(visible);
                2'd2:    m_rd = 32'(m_mask);
                2'd3:    m_rd = 32'(m_ec);
                default: m_rd = 32'd0;
            endcase
            clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
            m_ec = (m_ec & ~clr) | (visible & ~visible_before);
            if (wr && address == 2'd2) m_mask = writedata[W-1:0];
            seen[2] = seen[1];
            seen[1] = seen[0];
            seen[0] = in_port;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_val("readdata", readdata, m_rd);
            check_val("irq", {31'd0, irq}, {31'd0, |(m_ec & m_mask)});
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        step(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;

        // Reset state
        step(2);
        check_val("rst_readdata", readdata, 32'd0);
        check_val("rst_irq", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;
        step(2);

        // Rising bits 0 and 2 land in edgecapture after three edges
        address = 2'd3;
        in_port = 8'h05;
        step(3);
        check_val("ec_before_read", readdata, 32'd0);
        step(1);
        check_val("ec_05", readdata, 32'h5);
        check_val("irq_mask0", {31'd0, irq}, 32'd0);

        // Masked interrupt on bit 2, then cleared by software
        bus_write(2'd3, 32'hFF);
        bus_write(2'd2, 32'h04);
        in_port = 8'h00;
        step(3);
        in_port = 8'h04;
        step(2);
        check_val("irq_early", {31'd0, irq}, 32'd0);
        step(1);
        check_val("irq_set", {31'd0, irq}, 32'd1);
        bus_write(2'd3, 32'h04);
        check_val("irq_cleared", {31'd0, irq}, 32'd0);

        // Clear and new edge in the same cycle: the edge wins
        in_port = 8'h05;
        step(2);
        bus_write(2'd3, 32'h01);
        address = 2'd3;
        step(1);
        check_val("edge_wins", readdata, 32'h1);

        // Falling edges are not captured
        bus_write(2'd3, 32'hFF);
        in_port = 8'hFF;
        step(4);
        bus_write(2'd3, 32'hFF);
        in_port = 8'h00;
        step(4);
        address = 2'd3;
        step(1);
        check_val("no_fall_ec", readdata, 32'h0);
        address = 2'd0;
        step(1);
        check_val("data_zero", readdata, 32'h0);

        // Build edgecapture=A5 with full mask, then reset without a clock edge
        in_port = 8'hA5;
        step(3);
        bus_write(2'd2, 32'hFF);
        address = 2'd3;
        step(1);
        check_val("ec_a5", readdata, 32'hA5);
        check_val("irq_a5", {31'd0, irq}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("async_rst_rd", readdata, 32'h0);
        check_val("async_rst_irq", {31'd0, irq}, 32'd0);
        in_port = 8'h80;
        step(2);

        // Bit held high across reset release is captured three edges later
        @(negedge clk);
        reset_n = 1'b1;
        address = 2'd1;
        step(2);
        check_val("rsv_read", readdata, 32'h0);
        address = 2'd3;
        step(2);
        check_val("held_edge", readdata, 32'h80);
        bus_write(2'd0, 32'hFF);
        bus_write(2'd1, 32'hFF);
        address = 2'd2;
        step(1);
        check_val("mask_unchanged", readdata, 32'h0);
        address = 2'd3;
        step(1);
        check_val("ec_unchanged", readdata, 32'h80);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) in_port = W'($urandom);
            address    = 2'($urandom_range(0, 3));
            chipselect = ($urandom_range(0, 3) == 0);
            write_n    = ($urandom_range(0, 1) == 0);
            writedata  = $urandom;
            if ($urandom_range(0, 99) == 0) begin
                reset_n = 1'b0;
                step(1);
                reset_n = 1'b1;
            end
            step(1);
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nios2_sopc_pi_knn_resultado_classe.md
NIOS2_SOPC_PI_KNN_RESULTADO_CLASSE -- requirements
Module: nios2_sopc_pi_knn_resultado_classe

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, bit width of in_port and of every per-bit register.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; all sequential ports below follow from this.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 address  input  2  Avalon-MM slave word address: 0 data, 1 reserved, 2 irqmask, 3 edgecapture.
REQ-006 chipselect  input  1  slave select; qualifies writes.
REQ-007 write_n  input  1  active-low write strobe.
REQ-008 writedata  input  32  write data; only bits [WIDTH-1:0] used.
REQ-009 in_port  input  WIDTH  external asynchronous input from the KNN classifier (class result).
REQ-010 readdata  output  32  registered read data, zero-extended above WIDTH.
REQ-011 irq  output  1  level interrupt, active high.

Function
REQ-012 in_port SHALL pass through a 2-flop synchronizer (sync1, sync2); sync2 is the synchronized value.
REQ-013 A history register prev SHALL load sync2 every cycle; rising edge per bit = sync2 & ~prev.
REQ-014 edge_capture[i] SHALL set to 1 on a detected rising edge of bit i and hold until cleared by software.
REQ-015 A write (chipselect=1, write_n=0, address=3) SHALL clear each edge_capture bit whose writedata bit is 1; bits with writedata 0 unchanged.
REQ-016 Simultaneous clear and new rising edge on the same bit SHALL leave that bit set (edge wins).
REQ-017 A write to address 2 SHALL load irq_mask <= writedata[WIDTH-1:0].
REQ-018 Writes to address 0 or 1 SHALL have no effect.
REQ-019 irq SHALL equal |(edge_capture & irq_mask), combinationally from registers (no extra delay).
REQ-020 readdata SHALL register every cycle from the mux: addr0 sync2, addr1 0, addr2 irq_mask, addr3 edge_capture; read latency 1 cycle.
REQ-021 Reads SHALL have no side effects; chipselect is not required for readdata update.
REQ-022 Latency: in_port rising at clock edge N is visible in sync2 after edge N+2, in edge_capture and irq after edge N+3, in readdata (addr0) after edge N+3.
REQ-023 Pulses shorter than one clock period MAY be missed; pulses of 2+ cycles SHALL always be captured.
REQ-024 Falling edges SHALL NOT set edge_capture.

Reset
REQ-025 reset_n=0 SHALL asynchronously clear sync1, sync2, prev, edge_capture, irq_mask and readdata to 0; irq therefore 0.
REQ-026 Reset asserted mid-operation SHALL discard all captured edges and the mask; no state survives.
REQ-027 An in_port bit held high across reset release SHALL be captured as a rising edge 3 cycles after release (prev resets to 0).

Verification
REQ-028 Reset with in_port=0x00, then in_port=0x05 at cycle 10 -> edge_capture=0x05 at cycle 13; read addr3 returns 0x00000005; irq=0 (mask 0).
REQ-029 Write addr2=0x04, in_port rising on bit 2 -> irq=1 three cycles later; write addr3=0x04 -> edge_capture bit 2 cleared, irq=0 next cycle.
REQ-030 Hold in_port bit 0 rising while writing addr3=0x01 in the same cycle the edge is detected -> edge_capture[0] remains 1.
REQ-031 in_port 0xFF -> 0x00 after capture cleared -> edge_capture stays 0x00 (no falling-edge capture); read addr0 returns 0x00.
REQ-032 Assert reset_n=0 with edge_capture=0xA5, irq_mask=0xFF, irq=1 -> all registers 0 and irq=0 immediately, without a clock edge.
REQ-033 Release reset with in_port=0x80 held -> edge_capture=0x80 three cycles after release; read addr1 always returns 0; write to addr0 leaves all state unchanged.
